// File: rtl/detect_pkg.sv
// Shared constants and FSM state encoding for the droplet detect/resample chain.
// The state encoding is also decoded by the detector's debug tooling.
package detect_pkg;
  localparam int PERIOD_NUM = 21;
  localparam int PERIOD_W   = 128;
  localparam int SIZE_W     = 16;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_SIZE_READ  = 4'd1,
    ST_SIZE_LATCH = 4'd2,
    ST_LINE_WAIT  = 4'd3,
    ST_LINE_READ  = 4'd4,
    ST_LINE_LATCH = 4'd5,
    ST_EMIT_CHECK = 4'd6,
    ST_EMIT       = 4'd7,
    ST_LINE_NEXT  = 4'd8,
    ST_DONE       = 4'd9
  } state_t;
endpackage

// File: rtl/linebuf_ram.sv
// One-line period buffer: synchronous write, asynchronous read on a shared address.
module linebuf_ram import detect_pkg::*; #(
  parameter int DEPTH = PERIOD_NUM,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                clk,
  input  logic                we,
  input  logic [AW-1:0]       addr,
  input  logic [PERIOD_W-1:0] wdata,
  output logic [PERIOD_W-1:0] rdata
);
  logic [PERIOD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];
endmodule

// File: rtl/droplet_resample.sv
// Resamples a droplet to OUT_LINES lines by nearest-neighbour line selection
// using a DDA (acc/thr) over the input line count.
//
// state      | meaning
// IDLE       | wait for a size word
// SIZE_READ  | size FIFO pop in flight
// SIZE_LATCH | capture size, clear DDA counters
// LINE_WAIT  | wait for data, pop one period
// LINE_READ  | data FIFO pop in flight
// LINE_LATCH | write period into line buffer slot p
// EMIT_CHECK | decide whether the buffered line is emitted (again)
// EMIT       | stream the buffered line to the output FIFO
// LINE_NEXT  | advance to the next input line
// DONE       | pulse outdone
module droplet_resample import detect_pkg::*; #(
  parameter int PERIOD_NUM = detect_pkg::PERIOD_NUM,
  parameter int OUT_LINES  = 32,
  parameter int MAX_LINES  = 1023
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ce,
  input  logic [PERIOD_W-1:0]      datardata,
  input  logic                     dataempty,
  output logic                     datard,
  input  logic signed [SIZE_W-1:0] sizerdata,
  input  logic                     sizeempty,
  output logic                     sizerd,
  output logic [PERIOD_W-1:0]      outdata,
  output logic                     outwrite,
  input  logic                     outfull,
  output logic                     outdone,
  output logic [3:0]               stateoutput
);
  localparam int AW = (PERIOD_NUM > 1) ? $clog2(PERIOD_NUM) : 1;
  localparam logic [AW-1:0] P_LAST = AW'(PERIOD_NUM - 1);

  state_t              state;
  logic [AW-1:0]       p;
  logic [SIZE_W-1:0]   s_lines;
  logic [SIZE_W-1:0]   j;
  logic [SIZE_W-1:0]   j_next;
  logic [7:0]          k;
  logic [31:0]         s_map;
  logic [31:0]         acc;
  logic [31:0]         thr;
  logic [PERIOD_W-1:0] buf_rdata;
  logic                buf_we;

  linebuf_ram #(.DEPTH(PERIOD_NUM), .AW(AW)) u_linebuf (
    .clk   (clk),
    .we    (buf_we),
    .addr  (p),
    .wdata (datardata),
    .rdata (buf_rdata)
  );

  assign buf_we      = ce && (state == ST_LINE_LATCH);
  // Write strobe is decoded from the live full flag so it can never coincide with full.
  assign outwrite    = ce && (state == ST_EMIT) && !outfull;
  assign outdata     = (state == ST_EMIT) ? buf_rdata : '0;
  assign stateoutput = state;
  assign j_next      = j + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      p       <= '0;
      s_lines <= '0;
      j       <= '0;
      k       <= '0;
      s_map   <= '0;
      acc     <= '0;
      thr     <= '0;
      datard  <= 1'b0;
      sizerd  <= 1'b0;
      outdone <= 1'b0;
    end else if (ce) begin
      datard  <= 1'b0;
      sizerd  <= 1'b0;
      outdone <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!sizeempty) begin
            sizerd <= 1'b1;
            state  <= ST_SIZE_READ;
          end
        end
        ST_SIZE_READ: state <= ST_SIZE_LATCH;
        ST_SIZE_LATCH: begin
          j   <= '0;
          k   <= '0;
          acc <= '0;
          thr <= 32'(OUT_LINES);
          p   <= '0;
          if (sizerdata <= 0) begin
            s_lines <= '0;
            s_map   <= '0;
            state   <= ST_IDLE;
          end else begin
            s_lines <= sizerdata;
            s_map   <= (sizerdata > MAX_LINES) ? 32'(MAX_LINES) : 32'(sizerdata);
            state   <= ST_LINE_WAIT;
          end
        end
        ST_LINE_WAIT: begin
          if (!dataempty) begin
            datard <= 1'b1;
            state  <= ST_LINE_READ;
          end
        end
        ST_LINE_READ: state <= ST_LINE_LATCH;
        ST_LINE_LATCH: begin
          if (p == P_LAST) begin
            p     <= '0;
            state <= ST_EMIT_CHECK;
          end else begin
            p     <= p + 1'b1;
            state <= ST_LINE_WAIT;
          end
        end
        ST_EMIT_CHECK: begin
          if ((acc < thr) && (k < 8'(OUT_LINES))) begin
            p     <= '0;
            state <= ST_EMIT;
          end else begin
            state <= ST_LINE_NEXT;
          end
        end
        ST_EMIT: begin
          if (!outfull) begin
            if (p == P_LAST) begin
              p     <= '0;
              acc   <= acc + s_map;
              k     <= k + 8'd1;
              state <= ST_EMIT_CHECK;
            end else begin
              p <= p + 1'b1;
            end
          end
        end
        ST_LINE_NEXT: begin
          thr   <= thr + 32'(OUT_LINES);
          j     <= j_next;
          state <= (j_next == s_lines) ? ST_DONE : ST_LINE_WAIT;
        end
        ST_DONE: begin
          outdone <= 1'b1;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: doc/droplet_resample.md
# droplet_resample

Downstream consumer of the droplet detector. Takes the background-removed droplet periods (128-bit words, 21 per line) and the per-droplet line count from two FIFOs, and resamples the droplet in the line (time) axis to a fixed `OUT_LINES` lines by nearest-neighbour line selection. The fixed-size result goes to an output FIFO for the classifier stage. Every input line is drained; each line is dropped, passed once, or repeated as the mapping requires.

## Interface
- `PERIOD_NUM`, default 21: 128-bit periods per line.
- `OUT_LINES`, default 32: output lines per droplet (1..255).
- `MAX_LINES`, default 1023: input sizes above this are clamped for mapping only. All input lines are still drained.
- `clk` input, 1 bit: single clock, rising edge.
- `reset` input, 1 bit: asynchronous, active-high.
- `ce` input, 1 bit: clock enable. When low, all state, counters and outputs hold. Strobes already high remain high.
- `datardata` input, 128 bits: data FIFO read data, valid the cycle after `datard`.
- `dataempty` input, 1 bit: data FIFO empty.
- `datard` output, 1 bit: data FIFO read strobe, one-cycle pulse.
- `sizerdata` input, signed 16 bits: size FIFO read data, in lines.
- `sizeempty` input, 1 bit: size FIFO empty.
- `sizerd` output, 1 bit: size FIFO read strobe, one-cycle pulse.
- `outdata` output, 128 bits: resampled period.
- `outwrite` output, 1 bit: output FIFO write strobe.
- `outfull` input, 1 bit: output FIFO full.
- `outdone` output, 1 bit: one-cycle pulse after the last word of a non-empty droplet.
- `stateoutput` output, 4 bits: debug copy of the state register.

## Operation
- States:
  - `Idle`, `SizeRead`, `SizeLatch`.
  - `LineWait`, `LineRead`, `LineLatch`.
  - `EmitCheck`, `Emit`, `LineNext`, `Done`.
- `Idle`:
  - if `sizeempty`=0, pulse `sizerd` and go to `SizeRead`.
- `SizeRead`:
  - go to `SizeLatch`.
- `SizeLatch`:
  - S = `sizerdata`. S ≤ 0 is treated as 0. S > `MAX_LINES` uses `MAX_LINES` for mapping, but the raw S lines are still drained.
  - Clear j=0, k=0, acc=0, thr=`OUT_LINES`.
  - If S=0, return to `Idle`. No data is read and `outdone` does not pulse. Otherwise go to `LineWait`.
- `LineWait` / `LineRead` / `LineLatch`:
  - If `dataempty`=0, pulse `datard`.
  - Next cycle, write `datardata` into line buffer slot p. p counts 0..`PERIOD_NUM`-1.
  - After slot `PERIOD_NUM`-1, go to `EmitCheck`. Otherwise return to `LineWait`.
  - The upstream detector writes its size only after all data for the droplet, so data reads never starve indefinitely.
- `EmitCheck`:
  - If acc < thr and k < `OUT_LINES`, go to `Emit` with p=0.
  - Otherwise go to `LineNext`.
- `Emit`:
  - Each cycle with `outfull`=0: `outdata` = buffer[p], `outwrite`=1, p increments.
  - `outfull`=1: `outwrite`=0, p holds.
  - After p=`PERIOD_NUM`-1 is written: acc += S_map, k += 1, go to `EmitCheck`.
- `LineNext`:
  - thr += `OUT_LINES`, j += 1.
  - If j = S, go to `Done`. Otherwise go to `LineWait`.
- `Done`:
  - pulse `outdone`, then go to `Idle`.
- Mapping: output line k carries input line floor(k·S_map/`OUT_LINES`). When S_map < `OUT_LINES`, lines repeat. When S_map > `OUT_LINES`, lines are dropped.
- Widths:
  - acc and thr are 32-bit unsigned and cannot overflow with the clamp.
  - j and S are 16-bit; k is 8-bit.

## Timing
- Reset values: `datard`, `sizerd`, `outwrite`, `outdone` = 0; `outdata` = 0; state = `Idle`; all counters = 0.
- FIFO read latency is 1 cycle: data is captured the cycle after the strobe. Strobes never assert two cycles in a row.
- Input rate is at best one word every 3 cycles.
- Emit sustains one word per cycle while `outfull`=0. `outwrite` is never high while `outfull` is high.
- Latency from size pop to first output word is at most 3 + 3·`PERIOD_NUM` + 1 cycles with no stalls.
- Reset asserted mid-droplet: everything clears immediately and the partial droplet is abandoned. Flushing the FIFOs is the system's responsibility.
- A droplet always produces exactly `OUT_LINES`·`PERIOD_NUM` words when S ≥ 1.

## Structure
- Shared package `detect_pkg`:
  - `PERIOD_NUM`, the 128-bit period width, the size width.
  - the state encoding, shared with the detector's debug decoding.
- Sub-module `linebuf_ram`:
  - `PERIOD_NUM` × 128 single-port RAM with synchronous write and asynchronous read.
  - Maps to distributed RAM.
- The FSM and DDA counters live in `droplet_resample`. The block is about 200 lines.

## Test plan
- S=32, `OUT_LINES`=32, word value = line·256+period → 672 words out in order. `outdone` pulses once.
- S=64 → output line k carries input line 2k, i.e. lines 0, 2, …, 62. All 1344 input words are drained and `dataempty` ends at 1.
- S=16 → each input line is emitted twice consecutively: 32 lines, 672 words.
- S=0 and S=−5 → one size pop each, no data reads, no `outwrite`, no `outdone`.
- `outfull` toggled every other cycle during S=32 → same 672 words, none lost or duplicated, no `outwrite` while full.
- Reset asserted at word 100 of output → all strobes 0 next cycle and state is `Idle`. A fresh S=32 droplet afterwards is correct.
